// File: rtl/cpu_bus_master.sv
// 386SX-style bus master: one command at a time through T1/T2 with hold/holda arbitration.
// Optional T2 timeout abort is enabled by defining CPU_BUS_TIMEOUT_EN.
module cpu_bus_master #(
  parameter int ADS_CLKS = 2
`ifdef CPU_BUS_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 255
`endif
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [22:0] cmd_addr,
  input  logic [1:0]  cmd_be_n,
  input  logic [2:0]  cmd_type,
  input  logic [15:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic        ads_n,
  input  logic        ready_n,
  output logic [22:0] address,
  output logic [3:0]  bcd,
  output logic [1:0]  be_n,
  output logic [15:0] data_out,
  output logic        data_oe,
  input  logic [15:0] data_in,
  input  logic        hold,
  output logic        holda
);

  localparam int ADS_W = (ADS_CLKS > 1) ? $clog2(ADS_CLKS) : 1;
  localparam logic [ADS_W-1:0] ADS_LAST = ADS_W'(ADS_CLKS - 1);

  typedef enum logic [1:0] {IDLE, T1, T2, HOLD} state_t;

  state_t           state, state_nxt;
  logic [ADS_W-1:0] ads_cnt;
  logic             accept;
  logic             done;
  logic             timeout;

`ifdef CPU_BUS_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] to_cnt;
`endif

  assign cmd_ready = (state == IDLE) && !hold;
  assign accept    = cmd_valid && cmd_ready;

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    timeout   = 1'b0;
    case (state)
      IDLE: begin
        if (hold)           state_nxt = HOLD;
        else if (cmd_valid) state_nxt = T1;
      end
      T1: begin
        if (ads_cnt == ADS_LAST) state_nxt = T2;
      end
      T2: begin
        if (!ready_n) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
`ifdef CPU_BUS_TIMEOUT_EN
        else if (to_cnt == TO_LAST) begin
          done      = 1'b1;
          timeout   = 1'b1;
          state_nxt = IDLE;
        end
`endif
      end
      HOLD: begin
        if (!hold) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Bus-side outputs are all registered; the latched command lives in address/be_n/bcd/data_out.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ads_n     <= 1'b1;
      ads_cnt   <= '0;
      address   <= '0;
      be_n      <= 2'b11;
      bcd       <= '0;
      data_out  <= '0;
      data_oe   <= 1'b0;
      holda     <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= done;
      holda     <= (state_nxt == HOLD);
      if (accept) begin
        address  <= cmd_addr;
        be_n     <= cmd_be_n;
        bcd      <= {1'b0, cmd_type};
        data_out <= cmd_wdata;
        ads_n    <= 1'b0;
        ads_cnt  <= '0;
      end
      if (state == T1) begin
        data_oe <= bcd[0];
        if (ads_cnt == ADS_LAST) ads_n <= 1'b1;
        else                     ads_cnt <= ads_cnt + ADS_W'(1);
      end
      if (done) begin
        data_oe <= 1'b0;
        if (timeout)      rsp_rdata <= 16'hFFFF;
        else if (!bcd[0]) rsp_rdata <= data_in;
      end
    end
  end

`ifdef CPU_BUS_TIMEOUT_EN
  // Counter is cleared while in T1 so it starts from zero on the first T2 clock.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      to_cnt  <= '0;
      rsp_err <= 1'b0;
    end else begin
      if (state == T1)                to_cnt <= '0;
      else if (state == T2 && ready_n) to_cnt <= to_cnt + 8'd1;
      if (done) rsp_err <= timeout;
    end
  end
`else
  assign rsp_err = 1'b0;
`endif

endmodule
